// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank writer: FSM states and operation codes.
package jk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_TOGGLE = 1'b1;

    function automatic logic state_is_busy(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/jk_bank_writer_if.sv
// Request/response and J/K/Q signals between the writer and its JK bank.
interface jk_bank_writer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start, op, target, q_in,
        output j, k, busy, done, error
    );

    modport slave (
        output start, op, target, q_in,
        input  j, k, busy, done, error
    );
endinterface

// File: rtl/jk_excite.sv
// Combinational JK excitation: explicit set/reset per bit for write, J=K=mask for toggle.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_expected,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_j[gi] = (i_op == OP_TOGGLE) ? i_mask[gi] :  i_expected[gi];
            assign o_k[gi] = (i_op == OP_TOGGLE) ? i_mask[gi] : ~i_expected[gi];
        end
    endgenerate

endmodule

// File: rtl/jk_bank_writer.sv
// Drives a JK flip-flop bank to a target word (write) or toggles masked bits,
// then verifies the bank's Q outputs and reports done or error.
module jk_bank_writer
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              clear,
    jk_bank_writer_if.master  bus
);

    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_op;
    logic             w_op_next;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_exp_next;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_next;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_next;

    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_exp_next   = r_exp;
        w_mask_next  = r_mask;
        w_retry_next = r_retry;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_op_next    = bus.op;
                    w_mask_next  = bus.target;
                    // Toggle's expected result is taken from the bank as it stands at the start edge
                    w_exp_next   = (bus.op == OP_WRITE) ? bus.target : (bus.q_in ^ bus.target);
                    w_retry_next = 4'd0;
                    w_state_next = DRIVE;
                end
            end
            DRIVE: w_state_next = CHECK;
            CHECK: begin
                if (bus.q_in == r_exp) begin
                    w_state_next = DONE;
                end else if ((r_op == OP_WRITE) && (r_retry < RETRY_LAST)) begin
                    w_retry_next = r_retry + 4'd1;
                    w_state_next = DRIVE;
                end else begin
                    // Toggle is never retried: a second drive would flip the bits back
                    w_state_next = ERR;
                end
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Excitation is computed from next-cycle values so j/k are registered alongside the DRIVE state
    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .i_op       (w_op_next),
        .i_expected (w_exp_next),
        .i_mask     (w_mask_next),
        .o_j        (w_j),
        .o_k        (w_k)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_op    <= OP_WRITE;
            r_exp   <= '0;
            r_mask  <= '0;
            r_retry <= 4'd0;
            r_j     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_exp   <= w_exp_next;
            r_mask  <= w_mask_next;
            r_retry <= w_retry_next;
            r_j     <= (w_state_next == DRIVE) ? w_j : '0;
            r_k     <= (w_state_next == DRIVE) ? w_k : '0;
            r_busy  <= state_is_busy(w_state_next);
            r_done  <= (w_state_next == DONE);
            r_error <= (w_state_next == ERR);
        end
    end

    assign bus.j     = r_j;
    assign bus.k     = r_k;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.error = r_error;

endmodule
